irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 122 ++++++++++++
 tb/tb_irq_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - fixed-priority edge-triggered interrupt controller with ack handshake
module irq_controller #(
    parameter int          NUM_SRC     = 4,
    parameter logic [15:0] VEC_BASE    = 16'h0000,
    parameter int          HOLDOFF     = 2,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] mask,
    output logic               interrupt,
    input  logic               ack,
    output logic [15:0]        vector,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic               timeout_err
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [7:0]         cnt, cnt_nxt;
    logic               tmo_nxt;

    assign edges    = irq_src & ~irq_prev;
    assign eligible = pending & ~mask;

    // Scan from the top down so the lowest eligible index is the last one written.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // cnt counts unacknowledged REQ cycles, then is reused to time the HOLD window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        clr       = '0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sel_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = SERVICE;
                    cnt_nxt   = '0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (IDX_W'(i) == grant) begin
                            clr[i] = 1'b1;
                        end
                    end
                end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                    cnt_nxt = '0;
                    tmo_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            SERVICE: begin
                if (!ack) begin
                    cnt_nxt   = '0;
                    state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (cnt == 8'(HOLDOFF - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            // Sampling the lines here keeps a level already high at release from looking like an edge.
            irq_prev    <= irq_src;
            pending     <= '0;
            cnt         <= '0;
            grant       <= '0;
            interrupt   <= 1'b0;
            vector      <= VEC_BASE;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            irq_prev    <= irq_src;
            pending     <= (pending & ~clr) | edges;
            cnt         <= cnt_nxt;
            timeout_err <= tmo_nxt;
            interrupt   <= (state == REQ) && !ack;
            busy        <= (state_nxt != IDLE);
            if (state == IDLE && sel_valid) begin
                grant  <= sel_idx;
                vector <= VEC_BASE + 16'(sel_idx);
            end
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and randomized checks of irq_controller against a behavioural model
module tb_irq_controller;
    localparam int          N  = 4;
    localparam logic [15:0] VB = 16'h0000;
    localparam int          HO = 2;
    localparam int          TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic [N-1:0] mask = '0;
    logic         ack = 1'b0;
    logic         interrupt;
    logic [15:0]  vector;
    logic [N-1:0] pending;
    logic         busy;
    logic         timeout_err;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: a request is "asked", "in service", or "cooling down" for a number of cycles.
    bit [N-1:0]  m_prev, m_pend;
    bit          m_asking, m_serving;
    int          m_cool, m_wait, m_grant;
    bit          m_irq, m_tmo, m_busy;
    logic [15:0] m_vec;

    irq_controller #(.NUM_SRC(N), .VEC_BASE(VB), .HOLDOFF(HO), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .mask(mask), .interrupt(interrupt),
        .ack(ack), .vector(vector), .pending(pending), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] edges, elig;
        int k;
        if (!rst) begin
            m_prev = irq_src; m_pend = '0; m_asking = 0; m_serving = 0; m_cool = 0;
            m_wait = 0; m_grant = 0; m_irq = 0; m_vec = VB; m_busy = 0; m_tmo = 0;
        end else begin
            edges  = irq_src & ~m_prev;
            m_prev = irq_src;
            m_irq  = m_asking && !ack;
            m_tmo  = 0;
            if (m_asking) begin
                if (ack) begin
                    m_asking = 0; m_serving = 1; m_pend[m_grant] = 1'b0;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin m_wait = 0; m_tmo = 1; end
                end
            end else if (m_serving) begin
                if (!ack) begin m_serving = 0; m_cool = HO; end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                elig = m_pend & ~mask;
                k = -1;
                for (int i = 0; i < N; i++) if (elig[i] && k < 0) k = i;
                if (k >= 0) begin
                    m_asking = 1; m_grant = k; m_vec = VB + 16'(k); m_wait = 0;
                end
            end
            m_pend = m_pend | edges;
            m_busy = m_asking || m_serving || (m_cool > 0);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ".interrupt"}, 16'(interrupt), 16'(m_irq));
        chk({tag, ".vector"}, vector, m_vec);
        chk({tag, ".pending"}, 16'(pending), 16'(m_pend));
        chk({tag, ".busy"}, 16'(busy), 16'(m_busy));
        chk({tag, ".timeout_err"}, 16'(timeout_err), 16'(m_tmo));
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (interrupt !== 1'b1 && n < 40) begin tick(tag); n++; end
        vectors++;
        assert (n < 40) else begin
            miscompares++;
            $error("FAIL %s.irq_timeout: observed no interrupt after %0d cycles expected interrupt", tag, n);
        end
    endtask

    task automatic serve(input string tag, input logic [15:0] exp_vec);
        int n = 0;
        wait_irq(tag);
        chk({tag, ".vec"}, vector, exp_vec);
        tick(tag); tick(tag);
        chk({tag, ".vec_held"}, vector, exp_vec);
        ack = 1'b1;
        tick(tag);
        chk({tag, ".irq_drop"}, 16'(interrupt), 16'd0);
        ack = 1'b0;
        while (busy !== 1'b0 && n < 20) begin tick(tag); n++; end
        vectors++;
        assert (n < 20) else begin
            miscompares++;
            $error("FAIL %s.busy_timeout: observed busy stuck expected idle", tag);
        end
    endtask

    initial begin
        int cyc, last, pulses;

        // Reset state
        repeat (3) tick("reset");
        chk("reset.vector", vector, VB);
        rst = 1'b1;
        tick("idle");

        // Basic handshake with latency and holdoff timing
        irq_src = 4'b0100;
        tick("basic");
        irq_src = 4'b0000;
        tick("basic");
        chk("basic.lat2", 16'(interrupt), 16'd0);
        tick("basic");
        chk("basic.lat3", 16'(interrupt), 16'd1);
        chk("basic.vector", vector, 16'h0002);
        tick("basic"); tick("basic");
        ack = 1'b1;
        tick("basic");
        chk("basic.irq_drop", 16'(interrupt), 16'd0);
        chk("basic.pend2", 16'(pending[2]), 16'd0);
        ack = 1'b0;
        tick("basic"); tick("basic");
        chk("basic.busy_hold", 16'(busy), 16'd1);
        tick("basic");
        chk("basic.busy_idle", 16'(busy), 16'd0);

        // Priority and grant stability
        irq_src = 4'b1010;
        tick("prio");
        irq_src = 4'b0000;
        tick("prio"); tick("prio");
        irq_src = 4'b0001;
        tick("prio");
        irq_src = 4'b0000;
        tick("prio");
        chk("prio.stable", vector, 16'h0001);
        serve("prio1", 16'h0001);
        serve("prio0", 16'h0000);
        serve("prio3", 16'h0003);

        // Masking
        mask = 4'b0001;
        irq_src = 4'b0001;
        tick("mask");
        irq_src = 4'b0000;
        repeat (5) tick("mask");
        chk("mask.pend0", 16'(pending[0]), 16'd1);
        chk("mask.noirq", 16'(interrupt), 16'd0);
        mask = 4'b0000;
        serve("unmask", 16'h0000);

        // Ack timeout: pulses every TO cycles while interrupt stays up
        irq_src = 4'b0100;
        tick("tmo");
        irq_src = 4'b0000;
        wait_irq("tmo");
        pulses = 0; last = -1;
        for (cyc = 1; cyc <= 48; cyc++) begin
            tick("tmo");
            if (timeout_err === 1'b1) begin
                if (last >= 0) chk("tmo.spacing", 16'(cyc - last), 16'(TO));
                last = cyc;
                pulses++;
            end
        end
        chk("tmo.pulses", 16'(pulses), 16'd3);
        chk("tmo.irq_high", 16'(interrupt), 16'd1);
        tick("tmo");
        ack = 1'b1;
        tick("tmo");
        ack = 1'b0;
        repeat (4) tick("tmo");

        // Set wins over service clear
        irq_src = 4'b0010;
        tick("coll");
        irq_src = 4'b0000;
        wait_irq("coll");
        tick("coll");
        ack = 1'b1;
        irq_src = 4'b0010;
        tick("coll");
        chk("coll.pend1", 16'(pending[1]), 16'd1);
        ack = 1'b0;
        irq_src = 4'b0000;
        serve("coll_again", 16'h0001);

        // Reset mid-service with a level-high line at release
        irq_src = 4'b0100;
        tick("rstmid");
        irq_src = 4'b0000;
        wait_irq("rstmid");
        irq_src = 4'b1010;
        tick("rstmid");
        irq_src = 4'b0000;
        ack = 1'b1;
        tick("rstmid");
        chk("rstmid.pend", 16'(pending), 16'b1010);
        tick("rstmid");
        rst = 1'b0;
        irq_src = 4'b0100;
        tick("rstmid");
        chk("rstmid.pend0", 16'(pending), 16'd0);
        chk("rstmid.irq0", 16'(interrupt), 16'd0);
        chk("rstmid.vecbase", vector, VB);
        rst = 1'b1;
        repeat (6) tick("rstrel");
        chk("rstrel.pend", 16'(pending), 16'd0);
        chk("rstrel.irq", 16'(interrupt), 16'd0);
        ack = 1'b0;
        irq_src = 4'b0000;
        tick("rstrel");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            irq_src = N'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            ack     = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 99) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
